phase1_puzzle_sequencer: RTL and testbench

Phase-1 game controller that runs a fixed series of puzzle modules (the dial puzzle and its siblings) one at a time. It gives each puzzle an exclusive enable, shares the single 8-digit segment bank, LED bar and servo between puzzles, consumes their `clear`/`fail` pulses, and tracks a life counter. It sits between the top-level game FSM, which issues `start`/`abort`, and the per-puzzle instances.

---
 rtl/phase1_puzzle_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_phase1_puzzle_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/phase1_puzzle_sequencer.sv
// phase1_puzzle_sequencer
//   Runs NUM_PUZZLES puzzle modules one at a time. Each puzzle gets an
//   exclusive enable and is preceded by an INTRO banner of INTRO_CYCLES
//   cycles, during which its enable is low so it resets itself. The shared
//   segment bank, LED bar and servo are muxed from the active puzzle in RUN
//   and driven with fixed patterns in the other states. Fails consume lives.
// Ports:
//   clk, rst_n         system clock, async active-low reset
//   start              one-cycle pulse, begins a run from IDLE/WIN/LOSE
//   abort              level, forces IDLE (highest priority)
//   puzzle_clear/fail  per-puzzle result pulses
//   seg_in/led_in/servo_in  per-puzzle display slices (32/8/8 bits each)
//   puzzle_enable      one-hot (RUN) or zero enable to puzzles
//   seg_out/led_out/servo_out  shared display outputs
//   active_idx, lives  current puzzle index, remaining lives
//   busy               INTRO or RUN
//   phase_clear        one-cycle pulse on entry to WIN
//   game_over          level while in LOSE
module phase1_puzzle_sequencer #(
  parameter int NUM_PUZZLES  = 3,
  parameter int MAX_LIVES    = 3,
  parameter int INTRO_CYCLES = 25_000_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [NUM_PUZZLES-1:0]    puzzle_clear,
  input  logic [NUM_PUZZLES-1:0]    puzzle_fail,
  input  logic [32*NUM_PUZZLES-1:0] seg_in,
  input  logic [8*NUM_PUZZLES-1:0]  led_in,
  input  logic [8*NUM_PUZZLES-1:0]  servo_in,
  output logic [NUM_PUZZLES-1:0]    puzzle_enable,
  output logic [31:0]               seg_out,
  output logic [7:0]                led_out,
  output logic [7:0]                servo_out,
  output logic [1:0]                active_idx,
  output logic [3:0]                lives,
  output logic                      busy,
  output logic                      phase_clear,
  output logic                      game_over
);

  localparam int unsigned NP = NUM_PUZZLES;
  localparam int CW = (INTRO_CYCLES > 1) ? $clog2(INTRO_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(INTRO_CYCLES - 1);
  localparam logic [1:0]    IDX_LAST = 2'(NUM_PUZZLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_INTRO, S_RUN, S_WIN, S_LOSE} state_t;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_idx, w_idx_nxt;
  logic [3:0]      r_lives, w_lives_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_phase_clear, w_phase_clear_nxt;

  logic [NP-1:0]   w_onehot;
  logic            w_clr, w_fail;
  logic [3:0]      w_lives_dec;
  logic [31:0]     w_seg_sel;
  logic [7:0]      w_led_sel, w_servo_sel;

  // Decode the active index once; pulses and display slices are qualified
  // through it so non-active puzzles can never influence anything.
  always_comb begin
    w_onehot    = '0;
    w_seg_sel   = '0;
    w_led_sel   = '0;
    w_servo_sel = '0;
    for (int unsigned k = 0; k < NP; k++) begin
      if (r_idx == 2'(k)) begin
        w_onehot[k] = 1'b1;
        w_seg_sel   = seg_in[32*k +: 32];
        w_led_sel   = led_in[8*k +: 8];
        w_servo_sel = servo_in[8*k +: 8];
      end
    end
  end

  assign w_clr       = |(puzzle_clear & w_onehot);
  assign w_fail      = |(puzzle_fail & w_onehot);
  assign w_lives_dec = (r_lives == 4'd0) ? 4'd0 : r_lives - 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_lives       <= '0;
      r_cnt         <= '0;
      r_phase_clear <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_lives       <= w_lives_nxt;
      r_cnt         <= w_cnt_nxt;
      r_phase_clear <= w_phase_clear_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_lives_nxt       = r_lives;
    w_cnt_nxt         = r_cnt;
    w_phase_clear_nxt = 1'b0;
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = '0;
      w_lives_nxt = '0;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start) begin
            w_state_nxt = S_INTRO;
            w_idx_nxt   = '0;
            w_lives_nxt = 4'(MAX_LIVES);
            w_cnt_nxt   = '0;
          end
        end
        S_INTRO: begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_RUN: begin
          // Fail is applied before clear: losing the last life wins over
          // a simultaneous clear.
          if (w_fail) w_lives_nxt = w_lives_dec;
          if (w_fail && w_lives_dec == 4'd0) begin
            w_state_nxt = S_LOSE;
          end else if (w_clr) begin
            if (r_idx == IDX_LAST) begin
              w_state_nxt       = S_WIN;
              w_phase_clear_nxt = 1'b1;
            end else begin
              w_state_nxt = S_INTRO;
              w_idx_nxt   = r_idx + 2'd1;
              w_cnt_nxt   = '0;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    puzzle_enable = '0;
    seg_out       = 32'h0;
    led_out       = 8'h00;
    servo_out     = 8'd90;
    unique case (r_state)
      S_INTRO: seg_out = {{7{4'hB}}, ({2'b00, r_idx} + 4'd1)};
      S_RUN: begin
        puzzle_enable = w_onehot;
        seg_out       = w_seg_sel;
        led_out       = w_led_sel;
        servo_out     = w_servo_sel;
      end
      S_WIN: begin
        seg_out   = 32'hAAAA_AAAA;
        led_out   = 8'hFF;
        servo_out = 8'd180;
      end
      S_LOSE: begin
        seg_out   = 32'hEEEE_EEEE;
        servo_out = 8'd0;
      end
      default: ;
    endcase
  end

  assign active_idx  = r_idx;
  assign lives       = r_lives;
  assign busy        = (r_state == S_INTRO) || (r_state == S_RUN);
  assign phase_clear = r_phase_clear;
  assign game_over   = (r_state == S_LOSE);

endmodule

// File: tb/tb_phase1_puzzle_sequencer.sv
module tb_phase1_puzzle_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [2:0]  puzzle_clear, puzzle_fail;
  logic [95:0] seg_in;
  logic [23:0] led_in, servo_in;
  logic [2:0]  puzzle_enable;
  logic [31:0] seg_out;
  logic [7:0]  led_out, servo_out;
  logic [1:0]  active_idx;
  logic [3:0]  lives;
  logic        busy, phase_clear, game_over;

  int total = 0;
  int bad   = 0;
  logic done = 1'b0;

  phase1_puzzle_sequencer #(
    .NUM_PUZZLES(3),
    .MAX_LIVES(3),
    .INTRO_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .puzzle_clear(puzzle_clear), .puzzle_fail(puzzle_fail),
    .seg_in(seg_in), .led_in(led_in), .servo_in(servo_in),
    .puzzle_enable(puzzle_enable), .seg_out(seg_out), .led_out(led_out),
    .servo_out(servo_out), .active_idx(active_idx), .lives(lives),
    .busy(busy), .phase_clear(phase_clear), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    if (!done) begin
      total++;
      bad++;
      $error("FAIL timeout: simulation did not complete");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic through_intro(input logic [2:0] en_exp);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("intro_enable", puzzle_enable, 3'b000);
      chk("intro_busy", busy, 1'b1);
    end
    tick();
    chk("run_enable", puzzle_enable, en_exp);
  endtask

  task automatic pulse(input logic [2:0] clr, input logic [2:0] fl);
    puzzle_clear = clr;
    puzzle_fail  = fl;
    tick();
    puzzle_clear = '0;
    puzzle_fail  = '0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_enable"}, puzzle_enable, 3'b000);
    chk({tag, "_seg"}, seg_out, 32'h0);
    chk({tag, "_led"}, led_out, 8'h00);
    chk({tag, "_servo"}, servo_out, 8'd90);
    chk({tag, "_idx"}, active_idx, 2'd0);
    chk({tag, "_lives"}, lives, 4'd0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_pc"}, phase_clear, 1'b0);
    chk({tag, "_go"}, game_over, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    puzzle_clear = '0; puzzle_fail = '0;
    seg_in   = {32'h2222_2222, 32'h5555_5555, 32'h1111_0000};
    led_in   = {8'h33, 8'h22, 8'h11};
    servo_in = {8'd30, 8'd20, 8'd10};
    #2;
    check_idle("reset");
    #10 rst_n = 1'b1;
    tick();
    check_idle("idle");

    do_start();
    chk("intro0_seg", seg_out, 32'hBBBB_BBB1);
    chk("intro0_lives", lives, 4'd3);
    chk("intro0_servo", servo_out, 8'd90);
    through_intro(3'b001);
    chk("run0_seg", seg_out, 32'h1111_0000);
    chk("run0_led", led_out, 8'h11);
    chk("run0_servo", servo_out, 8'd10);
    pulse(3'b001, 3'b000);
    chk("intro1_seg", seg_out, 32'hBBBB_BBB2);
    chk("intro1_idx", active_idx, 2'd1);
    through_intro(3'b010);
    pulse(3'b001, 3'b100);
    chk("ignore_enable", puzzle_enable, 3'b010);
    chk("ignore_lives", lives, 4'd3);
    chk("ignore_idx", active_idx, 2'd1);
    seg_in[63:32] = 32'hBBB0_BBBB;
    #1;
    chk("mux_seg", seg_out, 32'hBBB0_BBBB);
    chk("mux_led", led_out, 8'h22);
    chk("mux_servo", servo_out, 8'd20);
    pulse(3'b010, 3'b000);
    chk("intro2_seg", seg_out, 32'hBBBB_BBB3);
    through_intro(3'b100);
    pulse(3'b100, 3'b000);
    chk("win_pc", phase_clear, 1'b1);
    chk("win_seg", seg_out, 32'hAAAA_AAAA);
    chk("win_led", led_out, 8'hFF);
    chk("win_servo", servo_out, 8'd180);
    chk("win_lives", lives, 4'd3);
    chk("win_enable", puzzle_enable, 3'b000);
    chk("win_busy", busy, 1'b0);
    tick();
    chk("win_pc_once", phase_clear, 1'b0);
    chk("win_hold", seg_out, 32'hAAAA_AAAA);

    do_start();
    chk("restart_lives", lives, 4'd3);
    chk("restart_idx", active_idx, 2'd0);
    through_intro(3'b001);
    pulse(3'b000, 3'b001);
    chk("fail1_lives", lives, 4'd2);
    chk("fail1_enable", puzzle_enable, 3'b001);
    pulse(3'b000, 3'b001);
    chk("fail2_lives", lives, 4'd1);
    pulse(3'b000, 3'b001);
    chk("fail3_lives", lives, 4'd0);
    chk("lose_go", game_over, 1'b1);
    chk("lose_enable", puzzle_enable, 3'b000);
    chk("lose_seg", seg_out, 32'hEEEE_EEEE);
    chk("lose_led", led_out, 8'h00);
    chk("lose_servo", servo_out, 8'd0);
    chk("lose_busy", busy, 1'b0);

    do_start();
    through_intro(3'b001);
    pulse(3'b000, 3'b001);
    pulse(3'b000, 3'b001);
    chk("cf1_pre_lives", lives, 4'd1);
    pulse(3'b001, 3'b001);
    chk("cf1_lives", lives, 4'd0);
    chk("cf1_go", game_over, 1'b1);
    chk("cf1_idx", active_idx, 2'd0);
    chk("cf1_pc", phase_clear, 1'b0);
    tick();
    chk("cf1_pc_after", phase_clear, 1'b0);

    do_start();
    through_intro(3'b001);
    pulse(3'b001, 3'b000);
    through_intro(3'b010);
    pulse(3'b010, 3'b000);
    through_intro(3'b100);
    pulse(3'b000, 3'b100);
    chk("cf2_pre_lives", lives, 4'd2);
    pulse(3'b100, 3'b100);
    chk("cf2_pc", phase_clear, 1'b1);
    chk("cf2_lives", lives, 4'd1);
    chk("cf2_seg", seg_out, 32'hAAAA_AAAA);
    tick();
    chk("cf2_pc_once", phase_clear, 1'b0);
    chk("cf2_lives_hold", lives, 4'd1);

    do_start();
    through_intro(3'b001);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check_idle("abort");
    tick();
    chk("abort_stay_busy", busy, 1'b0);

    do_start();
    tick();
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    #3 rst_n = 1'b1;
    tick();
    check_idle("post_rst");

    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
